// File: rtl/axi_ic_w_route.sv
// W-channel steering for one slave port: routes each burst's W beats from the AW-order winner, ending on the AW length.
// Zero-cycle combinational W path; AW side backpressured by aw_push_ready_o when Depth bursts are outstanding.
module axi_ic_w_route #(
    parameter int NumMasters = 2,
    parameter int DataWidth  = 32,
    parameter int Depth      = 4,
    localparam int GrantWidth = (NumMasters > 1) ? $clog2(NumMasters) : 1,
    localparam int StrbWidth  = DataWidth / 8,
    localparam int CntWidth   = $clog2(Depth) + 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            aw_push_valid_i,
    input  logic [GrantWidth-1:0]           aw_push_master_i,
    input  logic [7:0]                      aw_push_len_i,
    output logic                            aw_push_ready_o,
    input  logic [NumMasters-1:0]           s_wvalid_i,
    input  logic [NumMasters*DataWidth-1:0] s_wdata_i,
    input  logic [NumMasters*StrbWidth-1:0] s_wstrb_i,
    input  logic [NumMasters-1:0]           s_wlast_i,
    output logic [NumMasters-1:0]           s_wready_o,
    output logic                            m_wvalid_o,
    output logic [DataWidth-1:0]            m_wdata_o,
    output logic [StrbWidth-1:0]            m_wstrb_o,
    output logic                            m_wlast_o,
    input  logic                            m_wready_i,
    output logic                            len_err_o,
    output logic [CntWidth-1:0]             occupancy_o
);
    localparam int PtrWidth = $clog2(Depth);

    logic [GrantWidth-1:0] r_fifo_master [Depth];
    logic [7:0]            r_fifo_len    [Depth];
    logic [PtrWidth-1:0]   r_wptr;
    logic [PtrWidth-1:0]   r_rptr;
    logic [CntWidth-1:0]   r_count;
    logic [7:0]            r_beat_cnt;
    logic                  r_len_err;

    logic                  w_active;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_hs;
    logic                  w_last;
    logic                  w_src_last;
    logic [GrantWidth-1:0] w_head_master;
    logic [7:0]            w_head_len;

    assign w_head_master   = r_fifo_master[r_rptr];
    assign w_head_len      = r_fifo_len[r_rptr];
    assign w_active        = (r_count != '0) && !rst_i;
    assign w_full          = (r_count == CntWidth'(Depth));
    assign aw_push_ready_o = !w_full && !rst_i;
    assign w_push          = aw_push_valid_i && aw_push_ready_o;
    assign w_last          = (r_beat_cnt == w_head_len);
    assign w_hs            = m_wvalid_o && m_wready_i;
    assign w_pop           = w_hs && w_last;
    assign m_wlast_o       = w_last && w_active;
    assign len_err_o       = r_len_err;
    assign occupancy_o     = r_count;

    always_comb begin
        m_wvalid_o = 1'b0;
        m_wdata_o  = '0;
        m_wstrb_o  = '0;
        s_wready_o = '0;
        w_src_last = 1'b0;
        if (w_active) begin
            for (int i = 0; i < NumMasters; i++) begin
                if (w_head_master == GrantWidth'(i)) begin
                    m_wvalid_o    = s_wvalid_i[i];
                    m_wdata_o     = s_wdata_i[i*DataWidth +: DataWidth];
                    m_wstrb_o     = s_wstrb_i[i*StrbWidth +: StrbWidth];
                    s_wready_o[i] = m_wready_i;
                    w_src_last    = s_wlast_i[i];
                end
            end
        end
    end

    // Entry storage needs no reset: r_count gates every read of it.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_master[r_wptr] <= aw_push_master_i;
            r_fifo_len[r_wptr]    <= aw_push_len_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_beat_cnt <= '0;
            r_len_err  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_pop) begin
                r_beat_cnt <= '0;
            end else if (w_hs) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
            // Burst length comes from AW; a master's wlast is only audited.
            r_len_err <= w_hs && (w_src_last != w_last);
        end
    end
endmodule

// File: tb/tb_axi_ic_w_route.sv
// Randomized scoreboard bench for axi_ic_w_route with a burst-level reference model.
module tb_axi_ic_w_route;
    localparam int NM    = 2;
    localparam int DW    = 32;
    localparam int SW    = DW / 8;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst_i;
    logic            aw_push_valid_i;
    logic [0:0]      aw_push_master_i;
    logic [7:0]      aw_push_len_i;
    logic            aw_push_ready_o;
    logic [NM-1:0]   s_wvalid_i;
    logic [NM*DW-1:0] s_wdata_i;
    logic [NM*SW-1:0] s_wstrb_i;
    logic [NM-1:0]   s_wlast_i;
    logic [NM-1:0]   s_wready_o;
    logic            m_wvalid_o;
    logic [DW-1:0]   m_wdata_o;
    logic [SW-1:0]   m_wstrb_o;
    logic            m_wlast_o;
    logic            m_wready_i;
    logic            len_err_o;
    logic [2:0]      occupancy_o;

    always #5 clk = ~clk;

    axi_ic_w_route #(.NumMasters(NM), .DataWidth(DW), .Depth(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .aw_push_valid_i(aw_push_valid_i), .aw_push_master_i(aw_push_master_i),
        .aw_push_len_i(aw_push_len_i), .aw_push_ready_o(aw_push_ready_o),
        .s_wvalid_i(s_wvalid_i), .s_wdata_i(s_wdata_i), .s_wstrb_i(s_wstrb_i),
        .s_wlast_i(s_wlast_i), .s_wready_o(s_wready_o),
        .m_wvalid_o(m_wvalid_o), .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o),
        .m_wlast_o(m_wlast_o), .m_wready_i(m_wready_i),
        .len_err_o(len_err_o), .occupancy_o(occupancy_o)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic          last;
        logic          sent_last;
        int            master;
    } beat_t;

    beat_t tx_q[NM][$];
    beat_t exp_q[$];
    int    model_count;
    logic  exp_err;
    int    checks;
    int    errors;
    int    mode;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    // Slave-side model: beats leave in AW-acceptance order, len+1 beats per burst.
    always @(negedge clk) begin : monitor
        int    h;
        int    cnt_before;
        logic  hs;
        beat_t b;
        beat_t nb;
        if (rst_i) begin
            check("rst_aw_ready", aw_push_ready_o, 0);
            check("rst_w_gate", {m_wvalid_o, s_wready_o}, 0);
            check("rst_len_err", len_err_o, exp_err);
            exp_q.delete();
            for (int m = 0; m < NM; m++) tx_q[m].delete();
            model_count = 0;
            exp_err = 1'b0;
        end else begin
            cnt_before = model_count;
            check("occupancy", occupancy_o, model_count);
            check("aw_ready", aw_push_ready_o, model_count != DEPTH);
            check("len_err", len_err_o, exp_err);
            hs = 1'b0;
            h = 0;
            if (exp_q.size() == 0) begin
                check("idle_outputs", {m_wvalid_o, m_wlast_o, s_wready_o, m_wstrb_o, m_wdata_o}, 0);
            end else begin
                b = exp_q[0];
                h = b.master;
                check("m_wvalid", m_wvalid_o, s_wvalid_i[h]);
                check("s_wready", s_wready_o, m_wready_i ? (2'b01 << h) : 2'b00);
                if (s_wvalid_i[h])
                    check("beat", {m_wlast_o, m_wstrb_o, m_wdata_o}, {b.last, b.strb, b.data});
                hs = s_wvalid_i[h] && m_wready_i;
            end
            exp_err = 1'b0;
            if (hs) begin
                void'(exp_q.pop_front());
                void'(tx_q[h].pop_front());
                exp_err = (b.sent_last != b.last);
                if (b.last) model_count--;
            end
            if (aw_push_valid_i && cnt_before != DEPTH) begin
                model_count++;
                for (int k = 0; k <= int'(aw_push_len_i); k++) begin
                    nb.data      = $urandom;
                    nb.strb      = SW'($urandom);
                    nb.last      = (k == int'(aw_push_len_i));
                    nb.sent_last = ($urandom_range(0, 7) == 0) ? !nb.last : nb.last;
                    nb.master    = int'(aw_push_master_i);
                    exp_q.push_back(nb);
                    tx_q[nb.master].push_back(nb);
                end
            end
        end
    end

    task automatic drive();
        case (mode)
            1:       begin aw_push_valid_i = 1'b1; m_wready_i = 1'b0; end
            2:       begin aw_push_valid_i = 1'b0; m_wready_i = 1'b1; end
            default: begin
                aw_push_valid_i = ($urandom_range(0, 2) == 0);
                m_wready_i      = ($urandom_range(0, 1) == 0);
            end
        endcase
        aw_push_master_i = 1'($urandom_range(0, NM - 1));
        aw_push_len_i    = 8'($urandom_range(0, 3));
        for (int m = 0; m < NM; m++) begin
            if (tx_q[m].size() > 0 && (mode == 2 || $urandom_range(0, 3) != 0)) begin
                s_wvalid_i[m]         = 1'b1;
                s_wdata_i[m*DW +: DW] = tx_q[m][0].data;
                s_wstrb_i[m*SW +: SW] = tx_q[m][0].strb;
                s_wlast_i[m]          = tx_q[m][0].sent_last;
            end else begin
                s_wvalid_i[m]         = 1'b0;
                s_wdata_i[m*DW +: DW] = $urandom;
                s_wstrb_i[m*SW +: SW] = SW'($urandom);
                s_wlast_i[m]          = 1'($urandom);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_count = 0;
        exp_err = 1'b0;
        mode = 0;
        rst_i = 1'b1;
        aw_push_valid_i = 1'b0;
        aw_push_master_i = '0;
        aw_push_len_i = '0;
        s_wvalid_i = '0;
        s_wdata_i = '0;
        s_wstrb_i = '0;
        s_wlast_i = '0;
        m_wready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            mode  = (c % 300 >= 280) ? 1 : 0;
            rst_i = (c == 700);
            drive();
            @(posedge clk);
            #1;
        end
        rst_i = 1'b0;
        mode = 2;
        for (int c = 0; c < 400 && exp_q.size() != 0; c++) begin
            drive();
            @(posedge clk);
            #1;
        end
        check("drain_timeout", exp_q.size(), 0);
        drive();
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
